// File: rtl/pll_reset_seq.sv
// Staggered reset sequencer driven by a PLL lock indicator: waits for a stable
// lock, releases core, video and uart resets in turn, and re-asserts on lock loss.
module pll_reset_seq #(
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGGER       = 16,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       rst_core,
    output logic       rst_video,
    output logic       rst_uart,
    output logic       ready,
    output logic [7:0] loss_count
);

    localparam int SPAN_A    = (STABLE_CYCLES > 2 * STAGGER) ? STABLE_CYCLES : 2 * STAGGER;
    localparam int MAX_COUNT = (SPAN_A > GLITCH_CYCLES) ? SPAN_A : GLITCH_CYCLES;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] STABLE_END = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] VIDEO_AT   = CW'(STAGGER);
    localparam logic [CW-1:0] UART_AT    = CW'(2 * STAGGER);
    localparam logic [CW-1:0] GLITCH_END = CW'(GLITCH_CYCLES);

    typedef enum logic [1:0] {
        S_WAIT,
        S_STABLE,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          sync_q;
    logic          lk_s;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] glitch;
    logic [CW-1:0] glitch_next;
    logic          core_next;
    logic          video_next;
    logic          uart_next;
    logic          ready_next;
    logic [7:0]    loss_next;

    // Synchroniser, state and every output are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 1'b0;
            lk_s       <= 1'b0;
            state      <= S_WAIT;
            count      <= '0;
            glitch     <= '0;
            rst_core   <= 1'b1;
            rst_video  <= 1'b1;
            rst_uart   <= 1'b1;
            ready      <= 1'b0;
            loss_count <= 8'd0;
        end else begin
            sync_q     <= locked;
            lk_s       <= sync_q;
            state      <= state_next;
            count      <= count_next;
            glitch     <= glitch_next;
            rst_core   <= core_next;
            rst_video  <= video_next;
            rst_uart   <= uart_next;
            ready      <= ready_next;
            loss_count <= loss_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        glitch_next = glitch;
        core_next   = rst_core;
        video_next  = rst_video;
        uart_next   = rst_uart;
        ready_next  = ready;
        loss_next   = loss_count;

        case (state)
            S_WAIT: begin
                core_next   = 1'b1;
                video_next  = 1'b1;
                uart_next   = 1'b1;
                ready_next  = 1'b0;
                count_next  = '0;
                glitch_next = '0;
                if (lk_s) begin
                    state_next = S_STABLE;
                    count_next = CW'(1);
                end
            end

            S_STABLE: begin
                if (!lk_s) begin
                    state_next = S_WAIT;
                    count_next = '0;
                end else if (count == STABLE_END) begin
                    state_next  = S_RELEASE;
                    count_next  = '0;
                    glitch_next = '0;
                    core_next   = 1'b0;
                end else begin
                    count_next = count + CW'(1);
                end
            end

            S_RELEASE, S_RUN: begin
                // A sustained lock loss aborts everything, including a release in flight.
                if (glitch == GLITCH_END) begin
                    state_next  = S_WAIT;
                    count_next  = '0;
                    glitch_next = '0;
                    core_next   = 1'b1;
                    video_next  = 1'b1;
                    uart_next   = 1'b1;
                    ready_next  = 1'b0;
                    if (loss_count != 8'hFF) begin
                        loss_next = loss_count + 8'd1;
                    end
                end else begin
                    glitch_next = lk_s ? '0 : glitch + CW'(1);
                    if (state == S_RELEASE) begin
                        count_next = count + CW'(1);
                        if (count_next == VIDEO_AT) begin
                            video_next = 1'b0;
                        end
                        if (count_next == UART_AT) begin
                            uart_next  = 1'b0;
                            ready_next = 1'b1;
                            state_next = S_RUN;
                            count_next = '0;
                        end
                    end
                end
            end

            default: begin
                state_next = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: an event-level model checked every
// cycle, plus directed scenarios with hand-computed cycle expectations.
module tb_pll_reset_seq;

    localparam int STABLE = 8;
    localparam int STAG   = 4;
    localparam int GLITCH = 3;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       rst_core;
    logic       rst_video;
    logic       rst_uart;
    logic       ready;
    logic [7:0] loss_count;

    int n_compared;
    int n_mismatch;
    int edges;
    int base;

    // Model state: locked history, release progress and run lengths.
    int  smp0;
    int  smp1;
    int  lk;
    int  since;
    int  high_run;
    int  low_run;
    int  losses;
    bit  model_valid;

    pll_reset_seq #(
        .STABLE_CYCLES(STABLE),
        .STAGGER      (STAG),
        .GLITCH_CYCLES(GLITCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .locked    (locked),
        .rst_core  (rst_core),
        .rst_video (rst_video),
        .rst_uart  (rst_uart),
        .ready     (ready),
        .loss_count(loss_count)
    );

    initial begin
        clk = 1'b0;
        forever #17 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, edges - base - 1);
        end
    endtask

    // Model: release happens on the (STABLE+1)th consecutive synchronised-high
    // observation; afterwards outputs follow the age of the release, and GLITCH
    // consecutive lows trigger a loss on the following edge.
    initial begin
        edges       = 0;
        model_valid = 1'b0;
        forever begin
            @(posedge clk);
            edges++;
            if (rst) begin
                smp0 = 0; smp1 = 0; since = -1;
                high_run = 0; low_run = 0; losses = 0;
                model_valid = 1'b1;
            end else begin
                lk = smp1;
                if (since < 0) begin
                    high_run = (lk != 0) ? high_run + 1 : 0;
                    if (high_run == STABLE + 1) begin
                        since = 0; high_run = 0; low_run = 0;
                    end
                end else if (low_run == GLITCH) begin
                    since = -1; high_run = 0; low_run = 0;
                    losses = (losses < 255) ? losses + 1 : 255;
                end else begin
                    low_run = (lk != 0) ? 0 : low_run + 1;
                    if (since < 2 * STAG) since++;
                end
                smp1 = smp0;
                smp0 = int'(locked);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check_output("model rst_core",   rst_core,   8'(since < 0));
                check_output("model rst_video",  rst_video,  8'(since < STAG));
                check_output("model rst_uart",   rst_uart,   8'(since < 2 * STAG));
                check_output("model ready",      ready,      8'(since >= 2 * STAG));
                check_output("model loss_count", loss_count, 8'(losses));
            end
        end
    end

    task automatic apply_stimulus(input logic r, input logic l);
        rst    = r;
        locked = l;
    endtask

    task automatic wait_cycle(input int c);
        while (edges - base - 1 < c) @(negedge clk);
    endtask

    task automatic expect_outs(input string tag, input logic c, input logic v,
                               input logic u, input logic rd, input logic [7:0] lc);
        check_output({tag, " rst_core"},   rst_core,   8'(c));
        check_output({tag, " rst_video"},  rst_video,  8'(v));
        check_output({tag, " rst_uart"},   rst_uart,   8'(u));
        check_output({tag, " ready"},      ready,      8'(rd));
        check_output({tag, " loss_count"}, loss_count, lc);
    endtask

    // Reset pulse, check the reset state, then release rst with locked=l so that
    // the next rising edge is cycle 0.
    task automatic start_scenario(input string tag, input logic l);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        expect_outs({tag, " in-reset"}, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        apply_stimulus(1'b0, l);
        base = edges;
    endtask

    initial begin
        n_compared = 0;
        n_mismatch = 0;
        base       = 0;
        apply_stimulus(1'b1, 1'b0);

        // Locked from cycle 0, then short and long drops while running.
        start_scenario("steady", 1'b1);
        wait_cycle(9);  check_output("steady core@9",  rst_core, 8'd1);
        wait_cycle(10); check_output("steady core@10", rst_core, 8'd0);
                        check_output("steady video@10", rst_video, 8'd1);
        wait_cycle(13); check_output("steady video@13", rst_video, 8'd1);
        wait_cycle(14); check_output("steady video@14", rst_video, 8'd0);
                        check_output("steady uart@14", rst_uart, 8'd1);
        wait_cycle(17); expect_outs("steady@17", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        wait_cycle(18); expect_outs("steady@18", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        wait_cycle(24); locked = 1'b0;
        wait_cycle(26); locked = 1'b1;
        wait_cycle(35); expect_outs("shortdrop@35", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        wait_cycle(39); locked = 1'b0;
        wait_cycle(44); expect_outs("loss@44", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        wait_cycle(45); expect_outs("loss@45", 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);

        // One-cycle dropout while still stabilising restarts the count.
        start_scenario("restart", 1'b1);
        wait_cycle(4);  locked = 1'b0;
        wait_cycle(5);  locked = 1'b1;
        wait_cycle(10); check_output("restart core@10", rst_core, 8'd1);
        wait_cycle(15); check_output("restart core@15", rst_core, 8'd1);
        wait_cycle(16); check_output("restart core@16", rst_core, 8'd0);
        wait_cycle(20); check_output("restart video@20", rst_video, 8'd0);
        wait_cycle(24); expect_outs("restart@24", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Loss during the release window aborts it before uart is released.
        start_scenario("abort", 1'b1);
        wait_cycle(11); locked = 1'b0;
        wait_cycle(14); expect_outs("abort@14", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        wait_cycle(16); expect_outs("abort@16", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        locked = 1'b1;
        wait_cycle(17); expect_outs("abort@17", 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        wait_cycle(26); check_output("rerun core@26", rst_core, 8'd1);
        wait_cycle(27); check_output("rerun core@27", rst_core, 8'd0);
        wait_cycle(31); check_output("rerun video@31", rst_video, 8'd0);
        wait_cycle(35); expect_outs("rerun@35", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

        // rst while running re-asserts everything and restarts from the synchroniser.
        wait_cycle(40); rst = 1'b1;
        wait_cycle(41); expect_outs("rstrun@41", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        rst  = 1'b0;
        base = edges;
        wait_cycle(9);  check_output("rstrun core@9",  rst_core, 8'd1);
        wait_cycle(10); check_output("rstrun core@10", rst_core, 8'd0);

        // Drive 300 loss events; the counter must stick at 255.
        start_scenario("saturate", 1'b0);
        for (int i = 0; i < 300; i++) begin
            locked = 1'b1;
            repeat (13) @(negedge clk);
            locked = 1'b0;
            repeat (7) @(negedge clk);
        end
        expect_outs("saturate end", 1'b1, 1'b1, 1'b1, 1'b0, 8'd255);
        start_scenario("post-sat", 1'b0);
        repeat (3) @(negedge clk);
        expect_outs("post-sat", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
